rr_mux8to1: RTL and testbench
=============================

# rr_mux8to1

Eight-channel round-robin multiplexer that merges eight valid/ready source streams into one output stream. Each output word carries its source channel index on `out_sel`, so a downstream 1-to-8 demultiplexer can route it back using `out_sel[0]`/`[1]`/`[2]` as its s0/s1/s2 selects. It sits at the collecting end of a channelised datapath, between the eight producers and the shared link.

## Interface
- `W`, default 8: data width per channel.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  8  per-channel request; bit k belongs to channel k.
- `in_data`  input  8*W  channel k data on `in_data[k*W +: W]`.
- `in_ready`  output  8  one-hot accept strobe, combinational; at most one bit high.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  W  word being presented.
- `out_sel`  output  3  source channel of `out_data`; bit 0 = s0, bit 2 = s2.
- `out_ready`  input  1  downstream accept.

## Operation
- Transfer on input k: `in_valid[k] && in_ready[k]` at a rising edge. Transfer on output: `out_valid && out_ready` at a rising edge.
- Single-entry output register holds `out_data`, `out_sel` and `out_valid`.
- Load enable: `load = !out_valid || out_ready`.
- Pointer `last`, 3 bits, holds the last granted channel.
- Arbitration is combinational:
  - Search channels `last+1, last+2, …, last+8` in that order, mod 8.
  - The first k with `in_valid[k]` wins.
  - `in_ready[k] = load && (k == winner)`. Every other bit is 0.
  - If no channel requests, all `in_ready` bits are 0.
- On a rising edge with `load` high:
  - If a winner exists: `out_data <= in_data[winner]`, `out_sel <= winner`, `out_valid <= 1`, `last <= winner`.
  - If no winner: `out_valid <= 0`. `out_data`, `out_sel` and `last` hold.
- On a rising edge with `load` low: all state holds.
- While `out_valid && !out_ready`, `out_data` and `out_sel` must not change.
- Once a source asserts `in_valid`, it must hold it and its data stable until accepted. The block does not check this.
- Fairness: a continuously requesting channel waits at most 7 output transfers before it is granted.

## Timing
- Reset values (asynchronous, immediate): `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `last` = 7. Channel 0 has first priority after reset.
- While `rst_n` = 0, `in_ready` = 0.
- Latency: a word accepted at edge N is presented on `out_data` and `out_valid` after edge N, i.e. 1 cycle.
- Throughput: one word per cycle while `out_ready` stays high and any channel requests.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `last`. There is no path from `in_data` to `in_ready`.
- Simultaneous drain and refill: when `out_valid && out_ready` and a winner exists, the new word replaces the old one at the same edge, with no bubble.
- Reset asserted mid-stream:
  - The held word is dropped and `out_valid` falls immediately.
  - The pointer returns to 7.
  - Sources with a pending `in_valid` stay pending and are re-arbitrated from channel 0 after reset.
- Pointer wrap: after a grant to channel 7, the search starts again at channel 0.

## Test plan
- Reset with all `in_valid` = 0xFF and `out_ready` = 1 held throughout:
  - Grants are 0,1,…,7,0 on consecutive cycles.
  - `out_sel` follows 0..7 one cycle later.
  - `out_data` equals each channel's word.
- Single requester, `in_valid` = 0x20, data 0xA5, `out_ready` = 1:
  - `in_ready` = 0x20 on the next edge.
  - Next cycle: `out_valid` = 1, `out_sel` = 5, `out_data` = 0xA5.
  - No other `in_ready` bit is ever seen.
- Backpressure: `in_valid` = 0x09 with `out_ready` = 0 for 5 cycles:
  - Exactly one grant (channel 0) occurs.
  - `out_sel` = 0 holds stable and `in_ready` = 0 during the stall.
  - When `out_ready` rises, channel 3 is granted on that same edge with no bubble.
- Fairness under wrap: channel 6 requests continuously, channels 0 and 7 join after the first channel-6 grant.
  - Grant order is 7, 0, 6, 7, 0, 6.
- Idle gap: a single word accepted, then `in_valid` = 0 with `out_ready` = 1.
  - `out_valid` falls after one cycle.
  - `out_data` and `out_sel` keep their last values.
- Reset mid-stream: `rst_n` pulsed low while `out_valid` = 1 and `out_sel` = 4.
  - `out_valid`, `out_data` and `out_sel` are 0 immediately, without a clock edge.
  - After release with `in_valid` = 0x90, channel 4 is granted before channel 7.

Source files
------------

// File: rtl/rr_mux8to1.sv
// rr_mux8to1: eight-channel round-robin merge of valid/ready streams into a
// single registered output stream. Each output word is tagged with its source
// channel on out_sel so a downstream 1-to-8 demux can route it back.
module rr_mux8to1 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     in_valid,
    input  logic [8*W-1:0] in_data,
    output logic [7:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [2:0]     out_sel,
    input  logic           out_ready
);

    // Output register and round-robin pointer.
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    logic [2:0]     out_sel_q,   out_sel_d;
    logic [2:0]     last_q,      last_d;

    // Arbitration signals.
    logic [7:0]     rot_req;     // requests re-ordered so bit 0 is channel last+1
    logic           found;
    logic [2:0]     offset;
    logic [2:0]     winner;
    logic           load;
    logic           grant_en;
    logic [W-1:0]   chan_data [8];
    logic [W-1:0]   win_data;

    genvar gi;

    // Rotate the request vector so the search always starts at bit 0, and
    // split the flat data bus into per-channel words.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_chan
            logic [2:0] ch;
            // 3'(8) wraps to 0, so the last slot is the pointer itself.
            assign ch            = last_q + 3'(gi + 1);
            assign rot_req[gi]   = in_valid[ch];
            assign chan_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // Priority-encode the rotated requests: the lowest set bit is the channel
    // closest after the last grant.
    always_comb begin
        found  = 1'b0;
        offset = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) begin
                found  = 1'b1;
                offset = 3'(i);
            end
        end
        winner = last_q + offset + 3'd1;
    end

    // The output register can take a new word when empty or being drained.
    // Reset also blocks grants so no source sees a handshake while held.
    assign load     = !out_valid_q || out_ready;
    assign grant_en = rst_n && load && found;
    assign win_data = chan_data[winner];

    // One-hot accept strobe; depends only on valids, pointer and load.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ready
            assign in_ready[gi] = grant_en && (winner == 3'(gi));
        end
    endgenerate

    // Next-state: load the winner, or go empty if nobody requests; hold
    // everything while the downstream stalls a full register.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (load) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_data_d  = win_data;
                out_sel_d   = winner;
                last_d      = winner;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; pointer resets to 7 so channel 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 3'd0;
            last_q      <= 3'd7;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux8to1.sv
// Testbench for rr_mux8to1: table-driven cycle vectors with hand-derived
// in_ready/out_valid, a scoreboard queue for out_sel/out_data, and a few
// hand-written checks for idle hold, fairness order and mid-stream reset.
module tb_rr_mux8to1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_ready;

    rr_mux8to1 #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        logic       ordy;
        logic [7:0] exp_rdy;
        logic       exp_ov;
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    int         grant_log[$];
    logic [7:0] chan_data [8];
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int oh_idx(input logic [7:0] x);
        int r;
        r = -1;
        for (int k = 0; k < 8; k++) if (x[k]) r = k;
        return r;
    endfunction

    task automatic drive_data();
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = chan_data[k];
    endtask

    task automatic add(input logic [7:0] v, input logic ordy,
                       input logic [7:0] er, input logic eo);
        vec_t r;
        r.v = v; r.ordy = ordy; r.exp_rdy = er; r.exp_ov = eo;
        vecs.push_back(r);
    endtask

    // Called just after a rising edge: drive, check at the falling edge,
    // update the scoreboard, then advance past the next rising edge.
    task automatic apply(input int n);
        vec_t r;
        exp_t e;
        int   g;
        r = vecs[n];
        in_valid  = r.v;
        out_ready = r.ordy;
        drive_data();
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(r.exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(r.exp_ov));
        if (r.exp_ov) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty actual=valid required=queued word at %0t", $time);
            end else begin
                chk("out_sel", 32'(out_sel), 32'(sb[0].sel));
                chk("out_data", 32'(out_data), 32'(sb[0].data));
                if (r.ordy) void'(sb.pop_front());
            end
        end
        if (r.exp_rdy != 8'h00) begin
            g = oh_idx(r.exp_rdy);
            e.sel  = 3'(g);
            e.data = chan_data[g];
            sb.push_back(e);
        end
        if (in_ready != 8'h00) grant_log.push_back(oh_idx(in_ready));
        $display("vec %0d: in_valid=%02h out_ready=%0b in_ready=%02h out_valid=%0b out_sel=%0d out_data=%02h",
                 n, r.v, r.ordy, in_ready, out_valid, out_sel, out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int first, input int last);
        for (int n = first; n <= last; n++) apply(n);
    endtask

    initial begin
        int s1, s2, s3, s4, s5a, s5b, s_end;
        int glog_start;
        int fair_exp[7];

        for (int k = 0; k < 8; k++) chan_data[k] = 8'(8'h11 * (k + 1));

        // Segment 1: all channels requesting from reset, 0..7 then wrap to 0.
        s1 = vecs.size();
        for (int k = 0; k < 8; k++) add(8'hFF, 1'b1, 8'(1 << k), (k != 0));
        add(8'hFF, 1'b1, 8'h01, 1'b1);
        add(8'h00, 1'b1, 8'h00, 1'b1);
        // Segment 2: single requester, channel 5.
        s2 = vecs.size();
        add(8'h20, 1'b1, 8'h20, 1'b0);
        add(8'h00, 1'b1, 8'h00, 1'b1);
        add(8'h00, 1'b1, 8'h00, 1'b0);
        // Segment 3: backpressure, ch0 granted then ch3 waits five cycles.
        s3 = vecs.size();
        add(8'h09, 1'b0, 8'h01, 1'b0);
        for (int k = 0; k < 4; k++) add(8'h08, 1'b0, 8'h00, 1'b1);
        add(8'h08, 1'b1, 8'h08, 1'b1);
        add(8'h00, 1'b1, 8'h00, 1'b1);
        add(8'h00, 1'b1, 8'h00, 1'b0);
        // Segment 4: fairness across the wrap with channels 6, 7, 0.
        s4 = vecs.size();
        add(8'h40, 1'b1, 8'h40, 1'b0);
        add(8'hC1, 1'b1, 8'h80, 1'b1);
        add(8'hC1, 1'b1, 8'h01, 1'b1);
        add(8'hC1, 1'b1, 8'h40, 1'b1);
        add(8'hC1, 1'b1, 8'h80, 1'b1);
        add(8'hC1, 1'b1, 8'h01, 1'b1);
        add(8'hC1, 1'b1, 8'h40, 1'b1);
        add(8'h00, 1'b1, 8'h00, 1'b1);
        add(8'h00, 1'b1, 8'h00, 1'b0);
        // Segment 5a: load channel 4 and stall it.
        s5a = vecs.size();
        add(8'h10, 1'b0, 8'h10, 1'b0);
        // Segment 5b: after reset, channels 4 and 7 pending; 4 goes first.
        s5b = vecs.size();
        add(8'h90, 1'b1, 8'h10, 1'b0);
        add(8'h80, 1'b1, 8'h80, 1'b1);
        add(8'h00, 1'b1, 8'h00, 1'b1);
        add(8'h00, 1'b1, 8'h00, 1'b0);
        s_end = vecs.size();

        // Reset state with everyone requesting.
        rst_n     = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        drive_data();
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_sel", 32'(out_sel), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_hold_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        run(s1, s2 - 1);

        chan_data[5] = 8'hA5;
        run(s2, s3 - 1);
        // Idle gap: register empties but keeps the last word and tag.
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out_sel", 32'(out_sel), 32'd5);
        chk("idle_out_data", 32'(out_data), 32'hA5);

        run(s3, s4 - 1);

        glog_start = grant_log.size();
        run(s4, s5a - 1);
        fair_exp = '{6, 7, 0, 6, 7, 0, 6};
        if (grant_log.size() - glog_start != 7) begin
            chk("fair_grant_count", 32'(grant_log.size() - glog_start), 32'd7);
        end else begin
            for (int k = 0; k < 7; k++)
                chk("fair_grant_order", 32'(grant_log[glog_start + k]), 32'(fair_exp[k]));
        end

        run(s5a, s5b - 1);
        // Held word from channel 4, stalled, with 4 and 7 pending.
        in_valid  = 8'h90;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        chk("pre_reset_out_sel", 32'(out_sel), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_out_data", 32'(out_data), 32'd0);
        chk("midreset_out_sel", 32'(out_sel), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(s5b, s_end - 1);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
